// File: rtl/dma_req_arbiter_if.sv
// Handshake bundle between the DMA request arbiter, its layer controllers and the DMA engine.
// slave = arbiter view, master = requester/engine (environment) view.
interface dma_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*ADDR_W-1:0] req_start_addr;
  logic [NUM_REQ*ADDR_W-1:0] req_length;
  logic [NUM_REQ-1:0]        ack_out;
  logic [NUM_REQ-1:0]        dout_en_out;
  logic [NUM_REQ-1:0]        dout_eop_out;
  logic [DATA_W-1:0]         dout;
  logic                      eng_req;
  logic                      eng_ack;
  logic [ADDR_W-1:0]         eng_start_addr;
  logic [ADDR_W-1:0]         eng_length;
  logic                      eng_dout_en;
  logic                      eng_dout_eop;
  logic [DATA_W-1:0]         eng_dout;
  logic                      busy;
  logic                      err_len;
  logic [2:0]                err_id;

  modport slave (
    input  req_in, req_start_addr, req_length,
    input  eng_ack, eng_dout_en, eng_dout_eop, eng_dout,
    output ack_out, dout_en_out, dout_eop_out, dout,
    output eng_req, eng_start_addr, eng_length,
    output busy, err_len, err_id
  );

  modport master (
    output req_in, req_start_addr, req_length,
    output eng_ack, eng_dout_en, eng_dout_eop, eng_dout,
    input  ack_out, dout_en_out, dout_eop_out, dout,
    input  eng_req, eng_start_addr, eng_length,
    input  busy, err_len, err_id
  );
endinterface

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQ layer controllers,
// steering engine strobes to the granted layer and checking delivered beat count.
module dma_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512,
  parameter int CNT_W   = 27
) (
  input logic              clk,
  input logic              rst,
  dma_req_arbiter_if.slave bus
);
  localparam int IDX_W = 3;
  localparam logic [IDX_W:0]   NUM_REQ_L = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant, ptr, pick, off;
  logic [IDX_W:0]     sum;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic               eng_req_q, busy_q, err_len_q;
  logic [IDX_W-1:0]   err_id_q;
  logic [ADDR_W-1:0]  addr_q, len_q;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic [NUM_REQ-1:0] ack_v, en_v, eop_v;
  logic [DATA_W-1:0]  dout_w;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign rot = NUM_REQ'({bus.req_in, bus.req_in} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum  = {1'b0, ptr} + {1'b0, off};
    pick = IDX_W'((sum >= NUM_REQ_L) ? (sum - NUM_REQ_L) : sum);
  end

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      eng_req_q <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      err_len_q <= 1'b0;
      err_id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= pick;
            addr_q <= bus.req_start_addr[pick*ADDR_W +: ADDR_W];
            len_q  <= bus.req_length[pick*ADDR_W +: ADDR_W];
            busy_q <= 1'b1;
            state  <= REQ;
          end
        end
        // eng_req rises one cycle after entering REQ; acks are honoured only once it is up.
        REQ: begin
          if (eng_req_q && bus.eng_ack) begin
            eng_req_q <= 1'b0;
            cnt       <= '0;
            state     <= XFER;
          end else begin
            eng_req_q <= 1'b1;
          end
        end
        XFER: begin
          if (bus.eng_dout_en) begin
            cnt <= cnt_inc;
            if (bus.eng_dout_eop) begin
              if (ADDR_W'(cnt_inc) != len_q) begin
                err_len_q <= 1'b1;
                if (!err_len_q) err_id_q <= grant;
              end
              state <= DONE;
            end
          end
        end
        DONE: begin
          ptr    <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic sel;
    assign sel      = (grant == IDX_W'(i));
    assign ack_v[i] = sel && (state == REQ) && eng_req_q && bus.eng_ack;
    assign en_v[i]  = sel && (state == XFER) && bus.eng_dout_en;
    assign eop_v[i] = en_v[i] && bus.eng_dout_eop;
  end

  assign dout_w             = bus.eng_dout;
  assign bus.dout           = dout_w;
  assign bus.ack_out        = ack_v;
  assign bus.dout_en_out    = en_v;
  assign bus.dout_eop_out   = eop_v;
  assign bus.eng_req        = eng_req_q;
  assign bus.eng_start_addr = addr_q;
  assign bus.eng_length     = len_q;
  assign bus.busy           = busy_q;
  assign bus.err_len        = err_len_q;
  assign bus.err_id         = err_id_q;
endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: expected grants pushed to a scoreboard
// when requests are raised, popped and checked when ack/data strobes appear.
module tb_dma_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 27;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dma_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          g;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int          beats;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int g);
    return NR'(1) << g;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int b);
    return {448'b0, 32'hDA7A_0000, 32'(b)};
  endfunction

  // Monitor: ack pops the next expected grant; data strobes are checked against it.
  int cur_g  = 0;
  int mbeats = 0;
  int mexp   = 0;
  bit active = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      active = 1'b0;
    end else begin
      if (bus.ack_out != '0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", bus.ack_out, '0);
        end else begin
          me = sb.pop_front();
          chk("ack_grant", bus.ack_out, oh(me.g));
          chk("eng_start_addr", bus.eng_start_addr, me.addr);
          chk("eng_length", bus.eng_length, me.len);
          cur_g  = me.g;
          mexp   = me.beats;
          mbeats = 0;
          active = 1'b1;
        end
      end
      if (bus.dout_en_out != '0) begin
        chk("dout_en_route", bus.dout_en_out, active ? oh(cur_g) : '0);
        chk("dout_data", bus.dout, beat_data(mbeats));
        mbeats++;
        if (bus.dout_eop_out != '0) begin
          chk("dout_eop_route", bus.dout_eop_out, oh(cur_g));
          chk("beat_count", mbeats, mexp);
          active = 1'b0;
        end
      end else if (bus.dout_eop_out != '0) begin
        chk("eop_without_en", bus.dout_eop_out, '0);
      end
    end
  end

  task automatic set_slot(input int i, input int addr, input int len);
    bus.req_start_addr[i*AW +: AW] = AW'(addr);
    bus.req_length[i*AW +: AW]     = AW'(len);
  endtask

  task automatic wait_eng_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.eng_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic do_ack(input int dly, input logic [NR-1:0] clr);
    repeat (dly) @(posedge clk);
    #1 bus.eng_ack = 1'b1;
    @(posedge clk);
    #1 bus.eng_ack = 1'b0;
    bus.req_in = bus.req_in & ~clr;
  endtask

  task automatic do_beats(input int n, input int eop_at);
    for (int b = 0; b < n; b++) begin
      bus.eng_dout_en  = 1'b1;
      bus.eng_dout_eop = (b == eop_at);
      bus.eng_dout     = beat_data(b);
      @(posedge clk);
      #1;
    end
    bus.eng_dout_en  = 1'b0;
    bus.eng_dout_eop = 1'b0;
    bus.eng_dout     = '0;
  endtask

  task automatic xact(input int g, input int nbeats, input int ack_dly, input logic [NR-1:0] clr);
    sb.push_back('{g, bus.req_start_addr[g*AW +: AW], bus.req_length[g*AW +: AW], nbeats});
    wait_eng_req("eng_req_timeout");
    do_ack(ack_dly, clr);
    do_beats(nbeats, nbeats-1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_in         = '0;
    bus.req_start_addr = '0;
    bus.req_length     = '0;
    bus.eng_ack        = 1'b0;
    bus.eng_dout_en    = 1'b0;
    bus.eng_dout_eop   = 1'b0;
    bus.eng_dout       = '0;

    // Reset state
    #1;
    chk("rst_eng_req", bus.eng_req, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ack", bus.ack_out, '0);
    chk("rst_dout_en", bus.dout_en_out, '0);
    chk("rst_addr", bus.eng_start_addr, '0);
    chk("rst_len", bus.eng_length, '0);
    chk("rst_err_len", bus.err_len, 1'b0);
    chk("rst_err_id", bus.err_id, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Round robin: all four hold requests, 1-beat transfers, order 0,1,2,3,0,1
    for (int i = 0; i < NR; i++) set_slot(i, 100*i + 7, 1);
    @(posedge clk);
    #1 bus.req_in = 4'b1111;
    for (int i = 0; i < 6; i++) xact(i % NR, 1, 1, (i == 5) ? 4'b1111 : 4'b0000);
    repeat (3) @(negedge clk);
    chk("rr_idle_eng_req", bus.eng_req, 1'b0);
    chk("rr_idle_busy", bus.busy, 1'b0);
    chk("rr_sb_drained", sb.size(), 0);

    // Single request on layer 1 with latency check
    set_slot(1, 1252, 64);
    sb.push_back('{1, AW'(1252), AW'(64), 64});
    @(posedge clk);
    #1 bus.req_in = 4'b0010;
    @(negedge clk);
    chk("lat_c0_eng_req", bus.eng_req, 1'b0);
    @(negedge clk);
    chk("lat_c1_eng_req", bus.eng_req, 1'b0);
    chk("lat_c1_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("lat_c2_eng_req", bus.eng_req, 1'b1);
    chk("single_addr", bus.eng_start_addr, AW'(1252));
    chk("single_len", bus.eng_length, AW'(64));
    do_ack(3, 4'b0010);
    @(negedge clk);
    chk("single_eng_req_drop", bus.eng_req, 1'b0);
    do_beats(64, 63);
    @(negedge clk);
    chk("single_done_busy", bus.busy, 1'b1);
    chk("single_err_len", bus.err_len, 1'b0);
    @(negedge clk);
    chk("single_idle_busy", bus.busy, 1'b0);
    chk("single_idle_eng_req", bus.eng_req, 1'b0);

    // Spurious engine strobes while idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.eng_dout_en  = 1'b1;
      bus.eng_dout_eop = 1'b1;
      bus.eng_ack      = 1'b1;
      bus.eng_dout     = beat_data(0);
      @(negedge clk);
      chk("spur_dout_en", bus.dout_en_out, '0);
      chk("spur_eop", bus.dout_eop_out, '0);
      chk("spur_ack", bus.ack_out, '0);
      chk("spur_busy", bus.busy, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.eng_dout_en  = 1'b0;
    bus.eng_dout_eop = 1'b0;
    bus.eng_ack      = 1'b0;
    bus.eng_dout     = '0;

    // Length mismatch on layer 2 (eop on beat 63 of 64); later mismatch on 0 keeps err_id
    set_slot(2, 2000, 64);
    bus.req_in = 4'b0100;
    xact(2, 63, 1, 4'b0100);
    @(negedge clk);
    chk("mm_err_len", bus.err_len, 1'b1);
    chk("mm_err_id", bus.err_id, 3'd2);
    set_slot(0, 40, 5);
    bus.req_in = 4'b0001;
    xact(0, 3, 2, 4'b0001);
    @(negedge clk);
    chk("mm2_err_len", bus.err_len, 1'b1);
    chk("mm2_err_id", bus.err_id, 3'd2);

    // Reset during beat 10 of a transfer on layer 2
    set_slot(2, 3000, 20);
    sb.push_back('{2, AW'(3000), AW'(20), 20});
    bus.req_in = 4'b0100;
    wait_eng_req("rstx_eng_req_timeout");
    do_ack(1, 4'b0100);
    do_beats(9, -1);
    bus.eng_dout_en = 1'b1;
    bus.eng_dout    = beat_data(9);
    bus.req_in      = 4'b1000;
    set_slot(3, 4444, 0);
    #2 rst = 1'b0;
    #1;
    chk("rstx_dout_en", bus.dout_en_out, '0);
    chk("rstx_busy", bus.busy, 1'b0);
    chk("rstx_eng_req", bus.eng_req, 1'b0);
    chk("rstx_err_len", bus.err_len, 1'b0);
    chk("rstx_err_id", bus.err_id, 3'd0);
    chk("rstx_len", bus.eng_length, '0);
    bus.eng_dout_en = 1'b0;
    bus.eng_dout    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Pending layer 3 with length 0: one beat must flag a mismatch
    xact(3, 1, 2, 4'b1000);
    @(negedge clk);
    chk("len0_err_len", bus.err_len, 1'b1);
    chk("len0_err_id", bus.err_id, 3'd3);
    @(negedge clk);

    // Withdrawn request: layer 1 pulses one cycle while layer 0 is served
    set_slot(0, 500, 4);
    bus.req_in = 4'b0001;
    sb.push_back('{0, AW'(500), AW'(4), 4});
    wait_eng_req("wd_eng_req_timeout");
    do_ack(1, 4'b0001);
    bus.req_in = 4'b0010;
    @(posedge clk);
    #1 bus.req_in = 4'b0000;
    do_beats(4, 3);
    @(negedge clk);
    chk("wd_done_busy", bus.busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_eng_req", bus.eng_req, 1'b0);
      chk("wd_busy", bus.busy, 1'b0);
    end
    chk("final_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_req_arbiter.md
Name: dma_req_arbiter

Overview:
- Shares the single DMA engine port (512-bit weight-fetch channel) among NUM_REQ layer controllers. Each controller issues its own req/ack/start_addr/length transaction.
- Grants one requester at a time in round-robin order and forwards the request to the engine.
- Steers the engine's dout_en/dout_eop strobes to the granted requester; read data is broadcast to all requesters.
- Counts delivered beats against the requested length and flags mismatches.

Parameters:
- NUM_REQ, 4, number of requesting layers (2..8).
- ADDR_W, 27, width of start address and length.
- DATA_W, 512, DMA data width.
- CNT_W, 27, beat counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_in  in  NUM_REQ  per-layer dma_engineer_req, held high until its ack pulse
- req_start_addr  in  NUM_REQ*ADDR_W  packed per-layer start addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_length  in  NUM_REQ*ADDR_W  packed per-layer lengths, in DATA_W beats
- ack_out  out  NUM_REQ  per-layer ack, one-cycle pulse
- dout_en_out  out  NUM_REQ  per-layer data strobe
- dout_eop_out  out  NUM_REQ  per-layer end-of-packet
- dout  out  DATA_W  broadcast data
- eng_req  out  1  request to DMA engine
- eng_ack  in  1  engine accept pulse
- eng_start_addr  out  ADDR_W  address to engine
- eng_length  out  ADDR_W  length to engine
- eng_dout_en  in  1  engine data valid
- eng_dout_eop  in  1  engine last beat
- eng_dout  in  DATA_W  engine data
- busy  out  1  transaction in flight
- err_len  out  1  sticky: beat count differed from length at eop
- err_id  out  3  index of the first offending requester

Behaviour:
- Reset values (rst=0, async):
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer = 0.
  - err_len = 0, err_id = 0.
- FSM IDLE:
  - If any req_in bit is set, select the first set bit at or after pointer, wrapping modulo NUM_REQ.
  - Register the grant index g, and latch eng_start_addr/eng_length from slice g.
  - Go to REQ; eng_req=1 from the next cycle.
- FSM REQ:
  - eng_req held 1.
  - On eng_ack=1: ack_out[g]=1 in the same cycle (combinational: eng_ack & grant), eng_req=0 next cycle, beat counter cleared, go to XFER.
- FSM XFER:
  - dout_en_out[g] = eng_dout_en and dout_eop_out[g] = eng_dout_eop, combinational; all other bits 0.
  - dout = eng_dout, always, unregistered.
  - The beat counter increments on each eng_dout_en.
  - On eng_dout_en & eng_dout_eop:
    - Compare count+1 with the latched length. On mismatch, set err_len=1; if it was previously 0, also set err_id=g.
    - Go to DONE.
- FSM DONE, one cycle:
  - pointer = (g+1) mod NUM_REQ.
  - Go to IDLE. Rearbitration happens the following cycle, so there are at least 2 cycles between the eop and the next eng_req.
- busy = 1 in REQ, XFER and DONE.
- Latency: req_in rise to eng_req = 2 cycles, registered through IDLE→REQ.
- Requests:
  - Requests arriving while busy wait; they are not lost because req_in is level.
  - A requester dropping req_in before its grant is simply skipped.
  - Dropping req_in after the grant is ignored: the transaction completes.
  - Latched addr/length are frozen for the whole transaction.
- Engine strobes:
  - eng_dout_en outside XFER is ignored; no routing, no count.
  - eng_dout_eop without eng_dout_en is ignored.
  - eng_ack outside REQ is ignored.
- Length 0: forwarded as is. An eop on the first beat with length 0 flags err_len (count 1 ≠ 0).
- Beat counter: wraps at 2^CNT_W with no saturation; an error is flagged only via the compare.
- Reset mid-transaction: immediate return to IDLE, all strobes 0, errors cleared. The engine side is assumed to be reset together with the arbiter.
- Fairness: a continuously requesting layer waits at most NUM_REQ-1 transactions.

Test Plan:
- Single request: req_in=4'b0010, addr slice1=1252, len=64; engine acks 3 cycles later and sends 64 beats with eop on the last.
  - eng_req rises 2 cycles after req_in, eng_start_addr=1252, eng_length=64.
  - ack_out=4'b0010 for exactly 1 cycle.
  - dout_en_out[1] pulses 64 times, dout_eop_out[1] once.
  - err_len=0, busy falls after DONE.
- All four requesting continuously, 1-beat transfers: grant order 0,1,2,3,0,1; no requester granted twice in a row while others wait.
- Length mismatch: grant 2, len=64, engine sends eop on beat 63.
  - err_len=1, err_id=2.
  - A later mismatch on requester 0 leaves err_id=2.
- Spurious strobes: eng_dout_en/eng_ack pulses while IDLE → no dout_en_out or ack_out activity, counter unchanged.
- Reset mid-XFER: rst low during beat 10 → all outputs 0 asynchronously, FSM IDLE, pointer 0; after release, a pending req_in=4'b1000 is granted to requester 3.
- Withdrawn request: req_in[1] pulses for 1 cycle while busy with requester 0 → after DONE, requester 1 is not granted; arbiter returns to IDLE with eng_req=0.
